// File: rtl/reg_wr_decoder.sv
// Register write-port decoder with a pending-write scoreboard.
// Turns an (addr, en) write request into a registered one-hot select
// behind a valid/ready handshake. Each busy bit marks a write that is
// in flight; it is set when the write is accepted and cleared on retire.
// When ZR_MASK is set, the top index acts as a zero register: it is
// never decoded and never tracked.
module reg_wr_decoder #(
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZR_MASK = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic                     in_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(1<<ADDR_W)-1:0]   out_onehot,
  input  logic                     clr_valid,
  input  logic [ADDR_W-1:0]        clr_addr,
  output logic [(1<<ADDR_W)-1:0]   busy
);

  localparam int unsigned N = 1 << ADDR_W;

  logic [ADDR_W-1:0] zr_idx;
  logic [N-1:0]      dec;
  logic [N-1:0]      clr_mask;
  logic              hazard;
  logic              accept;

  assign zr_idx = '1;

  // Decode the request address, suppressing the masked zero register
  always_comb begin
    dec = '0;
    if (in_en && !(ZR_MASK && (in_addr == zr_idx))) begin
      dec[in_addr] = 1'b1;
    end
  end

  // Retire mask; the masked index is never tracked, so it is never cleared
  always_comb begin
    clr_mask = '0;
    if (clr_valid && !(ZR_MASK && (clr_addr == zr_idx))) begin
      clr_mask[clr_addr] = 1'b1;
    end
  end

  // Hazard looks at registered busy only: a same-cycle retire does not bypass
  always_comb begin
    hazard   = in_en && busy[in_addr];
    in_ready = !reset && (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  // Output register: load on accept, drain to zero on consume, hold on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_onehot <= dec;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
    end
  end

  // Scoreboard update; set is applied after clear so set wins on a collision
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | (accept ? dec : '0);
    end
  end

endmodule

// File: tb/tb_reg_wr_decoder.sv
// Directed bench for reg_wr_decoder (ADDR_W=5) with an output scoreboard.
module tb_reg_wr_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic        in_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_onehot;
  logic        clr_valid;
  logic [4:0]  clr_addr;
  logic [31:0] busy;

  logic        nz_in_ready;
  logic        nz_out_valid;
  logic [31:0] nz_out_onehot;
  logic [31:0] nz_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  reg_wr_decoder #(.ADDR_W(5), .ZR_MASK(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_en(in_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_onehot(out_onehot), .clr_valid(clr_valid),
    .clr_addr(clr_addr), .busy(busy)
  );

  reg_wr_decoder #(.ADDR_W(5), .ZR_MASK(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nz_in_ready),
    .in_addr(in_addr), .in_en(in_en), .out_valid(nz_out_valid),
    .out_ready(out_ready), .out_onehot(nz_out_onehot), .clr_valid(clr_valid),
    .clr_addr(clr_addr), .busy(nz_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_dec(input logic [4:0] a, input logic en);
    logic [31:0] v;
    v = '0;
    if (en && (a != 5'd31)) v[a] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: mid-cycle check of in_ready and scoreboard pop/push, then edge
  task automatic cyc(input string tag, input logic exp_rdy);
    logic [31:0] e;
    #3;
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, exp_rdy});
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".unexpected_out"}, out_onehot, 32'hxxxx_xxxx);
      end else begin
        e = sb_q.pop_front();
        chk({tag, ".sb_out"}, out_onehot, e);
      end
    end
    if (in_valid && exp_rdy && !reset) sb_q.push_back(exp_dec(in_addr, in_en));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic en);
    in_valid = v;
    in_addr  = a;
    in_en    = en;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; clr_valid = 1'b0; clr_addr = '0;
    drive(1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    cyc("rst_hold", 1'b0);
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.out_onehot", out_onehot, 32'd0);
    chk("rst.busy", busy, 32'd0);
    reset = 1'b0;
    cyc("post_rst", 1'b1);

    // Basic decode of index 10
    drive(1'b1, 5'd10, 1'b1);
    cyc("a10", 1'b1);
    chk("a10.out_valid", {31'b0, out_valid}, 32'd1);
    chk("a10.out_onehot", out_onehot, 32'h0000_0400);
    chk("a10.busy", busy, 32'h0000_0400);
    drive(1'b0, 5'd0, 1'b0);
    cyc("a10.drain", 1'b1);
    chk("a10.drained", out_onehot, 32'd0);

    // Hazard on busy index until the cycle after its retire
    drive(1'b1, 5'd10, 1'b1);
    cyc("haz1", 1'b0);
    cyc("haz2", 1'b0);
    clr_valid = 1'b1; clr_addr = 5'd10;
    cyc("haz_clr_nobypass", 1'b0);
    clr_valid = 1'b0;
    chk("haz.busy_cleared", busy, 32'd0);
    cyc("haz_accept", 1'b1);
    chk("haz.out_onehot", out_onehot, 32'h0000_0400);
    drive(1'b0, 5'd0, 1'b0);
    clr_valid = 1'b1; clr_addr = 5'd10;
    cyc("haz.retire", 1'b1);
    clr_valid = 1'b0;
    chk("haz.busy_zero", busy, 32'd0);

    // Zero-register masking versus unmasked instance
    drive(1'b1, 5'd31, 1'b1);
    cyc("zr", 1'b1);
    chk("zr.out_valid", {31'b0, out_valid}, 32'd1);
    chk("zr.out_onehot", out_onehot, 32'd0);
    chk("zr.busy", busy, 32'd0);
    chk("nz.out_onehot", nz_out_onehot, 32'h8000_0000);
    chk("nz.busy", nz_busy, 32'h8000_0000);
    drive(1'b0, 5'd0, 1'b0);
    clr_valid = 1'b1; clr_addr = 5'd31;
    cyc("zr.clr", 1'b1);
    clr_valid = 1'b0;
    chk("nz.busy_clr", nz_busy, 32'd0);
    chk("zr.busy_clr", busy, 32'd0);

    // Stall holds output, then replacement on release
    drive(1'b1, 5'd5, 1'b1);
    cyc("st.load", 1'b1);
    out_ready = 1'b0;
    drive(1'b1, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc("st.hold", 1'b0);
      chk("st.out_onehot", out_onehot, 32'h0000_0020);
      chk("st.out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    cyc("st.release", 1'b1);
    chk("st.new_out", out_onehot, 32'h0000_0001);
    chk("st.busy", busy, 32'h0000_0021);

    // en=0 request on a busy index: no hazard, zero output, busy untouched
    drive(1'b1, 5'd5, 1'b0);
    cyc("en0", 1'b1);
    chk("en0.out_valid", {31'b0, out_valid}, 32'd1);
    chk("en0.out_onehot", out_onehot, 32'd0);
    chk("en0.busy", busy, 32'h0000_0021);

    drive(1'b0, 5'd0, 1'b0);
    clr_valid = 1'b1; clr_addr = 5'd0;
    cyc("clr0", 1'b1);
    clr_addr = 5'd5;
    cyc("clr5", 1'b1);
    clr_valid = 1'b0;
    chk("clr.busy", busy, 32'd0);

    // Back-to-back stream 1,2,3
    drive(1'b1, 5'd1, 1'b1);
    cyc("s1", 1'b1);
    chk("s1.out", out_onehot, 32'h0000_0002);
    drive(1'b1, 5'd2, 1'b1);
    cyc("s2", 1'b1);
    chk("s2.out", out_onehot, 32'h0000_0004);
    drive(1'b1, 5'd3, 1'b1);
    cyc("s3", 1'b1);
    chk("s3.out", out_onehot, 32'h0000_0008);
    chk("s3.busy", busy, 32'h0000_000E);
    drive(1'b0, 5'd0, 1'b0);
    cyc("s.drain", 1'b1);

    // Set and clear on different indices in one cycle
    drive(1'b1, 5'd4, 1'b1);
    clr_valid = 1'b1; clr_addr = 5'd3;
    cyc("setclr", 1'b1);
    clr_valid = 1'b0;
    chk("setclr.busy", busy, 32'h0000_0016);

    // Reset mid-stall with a pending accept attempt
    out_ready = 1'b0;
    drive(1'b1, 5'd6, 1'b1);
    reset = 1'b1;
    cyc("rst2", 1'b0);
    chk("rst2.busy", busy, 32'd0);
    chk("rst2.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2.out_onehot", out_onehot, 32'd0);
    sb_q.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 5'd0, 1'b0);
    cyc("rst2.after", 1'b1);
    chk("sb.empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
